mhp_frame_parser: RTL and testbench

- Receive-side stage between the Ethernet RX FIFO byte interface and the MHP protocol FSM; the mirror of the frame assembly block.
- Pulls bytes with the rreq/rready handshake and deserialises header fields plus payload.
- Filters on destination address and presents one parsed frame at a time with valid/ack.

---
 rtl/mhp_pkg.sv | 31 +++
 rtl/mhp_frame_parser.sv | 179 +++++++++++++++++
 tb/tb_mhp_frame_parser.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mhp_pkg.sv
// mhp_pkg: constants, header layout and state encoding shared by the MHP frame
// parser and the frame assembly block.
package mhp_pkg;

  localparam int          HDR_LEN             = 7;
  localparam logic [15:0] BCAST_ADDR          = 16'hFFFF;
  localparam int          MAX_PAYLOAD_DEFAULT = 42;

  // Header byte offsets on the wire, MSB of each 16-bit field first.
  localparam int OFF_DST_HI  = 0;
  localparam int OFF_DST_LO  = 1;
  localparam int OFF_SRC_HI  = 2;
  localparam int OFF_SRC_LO  = 3;
  localparam int OFF_SIZE_HI = 4;
  localparam int OFF_SIZE_LO = 5;
  localparam int OFF_DIRTYPE = 6;

  localparam logic [6:0] TYPE_ADDR_REQ = 7'h03;
  localparam logic [6:0] TYPE_ADDR_ACK = 7'h04;
  localparam logic [6:0] TYPE_DATA     = 7'h10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_DRAIN   = 3'd5
  } state_e;

endpackage

// File: rtl/mhp_frame_parser.sv
// mhp_frame_parser: reads bytes from the RX FIFO, deserialises one MHP frame and
// presents it on valid/ack. Define MHP_FRAME_PARSER_CSUM_EN for a trailing XOR checksum.
//
// Handshakes: o_rreq is raised only while i_rready=1 and the byte arrives on
// i_rdata the next cycle; o_valid stays high with stable fields until i_ack.
module mhp_frame_parser
  import mhp_pkg::*;
#(
  parameter logic [15:0] MY_ADDR        = 16'h0000,
  parameter int          MAX_PAYLOAD    = MAX_PAYLOAD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 500
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_rdata,
  input  logic                     i_rready,
  output logic                     o_rreq,
  output logic                     o_valid,
  input  logic                     i_ack,
  output logic [15:0]              o_dst,
  output logic [15:0]              o_src,
  output logic [15:0]              o_size,
  output logic                     o_dir,
  output logic [6:0]               o_type,
  output logic [8*MAX_PAYLOAD-1:0] o_payload,
  output logic [7:0]               o_rx_count,
  output logic [7:0]               o_drop_count
);

`ifdef MHP_FRAME_PARSER_CSUM_EN
  localparam int TRAILER_LEN = 1;
`else
  localparam int TRAILER_LEN = 0;
`endif
  localparam logic [16:0] BASE_LIMIT = 17'(HDR_LEN + TRAILER_LEN);

  state_e      state;
  logic [15:0] req_cnt;
  logic [15:0] cap_cnt;
  logic        rd_pend;
  logic [9:0]  to_cnt;
  logic [16:0] limit;
  logic [15:0] pay_idx;
  logic        in_frame;
  logic        timeout_hit;
  logic        frame_ok;

`ifdef MHP_FRAME_PARSER_CSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign frame_ok = ((o_dst == MY_ADDR) || (o_dst == BCAST_ADDR)) && csum_ok;
`else
  assign frame_ok = (o_dst == MY_ADDR) || (o_dst == BCAST_ADDR);
`endif

  // Until the size field is complete only the header may be requested.
  always_comb begin
    limit = BASE_LIMIT;
    if (cap_cnt > 16'(OFF_SIZE_LO)) limit = BASE_LIMIT + {1'b0, o_size};
  end

  assign in_frame    = (state == ST_HDR) || (state == ST_PAYLOAD);
  assign timeout_hit = in_frame && !rd_pend && (to_cnt == 10'(TIMEOUT_CYCLES - 1));
  assign pay_idx     = cap_cnt - 16'(HDR_LEN);

  always_comb begin
    o_rreq = 1'b0;
    if (!i_rst && i_rready) begin
      case (state)
        ST_IDLE, ST_DRAIN:   o_rreq = 1'b1;
        ST_HDR, ST_PAYLOAD:  o_rreq = ({1'b0, req_cnt} < limit) && !timeout_hit;
        default:             o_rreq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      req_cnt      <= '0;
      cap_cnt      <= '0;
      rd_pend      <= 1'b0;
      to_cnt       <= '0;
      o_valid      <= 1'b0;
      o_dst        <= '0;
      o_src        <= '0;
      o_size       <= '0;
      o_dir        <= 1'b0;
      o_type       <= '0;
      o_payload    <= '0;
      o_rx_count   <= '0;
      o_drop_count <= '0;
`ifdef MHP_FRAME_PARSER_CSUM_EN
      csum         <= '0;
      csum_ok      <= 1'b0;
`endif
    end else begin
      rd_pend <= o_rreq;
      case (state)
        ST_IDLE: begin
          if (o_rreq) begin
            state     <= ST_HDR;
            req_cnt   <= 16'd1;
            cap_cnt   <= '0;
            to_cnt    <= '0;
            o_payload <= '0;
`ifdef MHP_FRAME_PARSER_CSUM_EN
            csum      <= '0;
            csum_ok   <= 1'b0;
`endif
          end
        end
        ST_HDR, ST_PAYLOAD: begin
          if (o_rreq) req_cnt <= req_cnt + 16'd1;
          if (rd_pend) begin
            to_cnt  <= '0;
            cap_cnt <= cap_cnt + 16'd1;
`ifdef MHP_FRAME_PARSER_CSUM_EN
            if (state == ST_PAYLOAD && pay_idx == o_size) csum_ok <= (csum == i_rdata);
            else csum <= csum ^ i_rdata;
`endif
            if (state == ST_HDR) begin
              case (cap_cnt)
                16'(OFF_DST_HI):  o_dst[15:8]     <= i_rdata;
                16'(OFF_DST_LO):  o_dst[7:0]      <= i_rdata;
                16'(OFF_SRC_HI):  o_src[15:8]     <= i_rdata;
                16'(OFF_SRC_LO):  o_src[7:0]      <= i_rdata;
                16'(OFF_SIZE_HI): o_size[15:8]    <= i_rdata;
                16'(OFF_SIZE_LO): o_size[7:0]     <= i_rdata;
                default:          {o_dir, o_type} <= i_rdata;
              endcase
              if (cap_cnt == 16'(OFF_DIRTYPE)) begin
                if (o_size > 16'(MAX_PAYLOAD))                   state <= ST_DRAIN;
                else if (o_size == 16'd0 && TRAILER_LEN == 0)   state <= ST_DONE;
                else                                             state <= ST_PAYLOAD;
              end
            end else begin
              for (int k = 0; k < MAX_PAYLOAD; k++) begin
                if (pay_idx == 16'(k) && pay_idx < o_size) o_payload[8*k +: 8] <= i_rdata;
              end
              if ({1'b0, cap_cnt} == limit - 17'd1) state <= ST_DONE;
            end
          end else if (timeout_hit) begin
            state        <= ST_IDLE;
            o_drop_count <= o_drop_count + 8'd1;
          end else begin
            to_cnt <= to_cnt + 10'd1;
          end
        end
        ST_DONE: begin
          if (frame_ok) begin
            o_valid    <= 1'b1;
            o_rx_count <= o_rx_count + 8'd1;
            state      <= ST_HOLD;
          end else begin
            o_drop_count <= o_drop_count + 8'd1;
            state        <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (i_ack) begin
            o_valid   <= 1'b0;
            o_payload <= '0;
            state     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // The byte still in flight when i_rready falls is simply discarded.
          if (!i_rready) begin
            o_drop_count <= o_drop_count + 8'd1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mhp_frame_parser.sv
// tb_mhp_frame_parser: directed table of frames through a byte FIFO model, plus
// hand-written timeout, hold/back-to-back, checksum and mid-frame reset sequences.
module tb_mhp_frame_parser;
  import mhp_pkg::*;

  localparam int MAXP = 42;
  localparam int PW   = 8 * MAXP;
`ifdef MHP_FRAME_PARSER_CSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [7:0]    i_rdata = 8'h00;
  logic          i_rready;
  logic          o_rreq;
  logic          o_valid;
  logic          i_ack = 1'b0;
  logic [15:0]   o_dst, o_src, o_size;
  logic          o_dir;
  logic [6:0]    o_type;
  logic [PW-1:0] o_payload;
  logic [7:0]    o_rx_count, o_drop_count;

  mhp_frame_parser #(.MY_ADDR(16'h0000), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(500)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rdata(i_rdata), .i_rready(i_rready), .o_rreq(o_rreq),
    .o_valid(o_valid), .i_ack(i_ack), .o_dst(o_dst), .o_src(o_src), .o_size(o_size),
    .o_dir(o_dir), .o_type(o_type), .o_payload(o_payload), .o_rx_count(o_rx_count),
    .o_drop_count(o_drop_count)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- RX FIFO model ----------------
  logic [7:0] mem [0:4095];
  int wr_ptr = 0, rd_ptr = 0;
  int rreq_cnt = 0, last_rreq = 0, cyc = 0, underflow = 0;
  logic [7:0] csum_acc;
  assign i_rready = (wr_ptr != rd_ptr);

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_rreq) begin
      if (rd_ptr == wr_ptr) underflow <= underflow + 1;
      else begin
        i_rdata <= mem[rd_ptr[11:0]];
        rd_ptr  <= rd_ptr + 1;
      end
      rreq_cnt  <= rreq_cnt + 1;
      last_rreq <= cyc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int checks = 0, errors = 0;
  int exp_rx = 0, exp_drop = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_pay(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pay_byte(input logic [7:0] seed, input int k);
    return seed + 8'(k) * 8'h11;
  endfunction

  function automatic logic [PW-1:0] exp_pay(input logic [7:0] seed, input int size);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < MAXP; k++) if (k < size) p[8*k +: 8] = pay_byte(seed, k);
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[11:0]] = b;
    wr_ptr   = wr_ptr + 1;
    csum_acc = csum_acc ^ b;
  endtask

  task automatic push_frame(input logic [15:0] dst, input logic [15:0] src, input logic [15:0] size,
                            input logic dir, input logic [6:0] typ, input logic [7:0] seed,
                            input logic bad_csum);
    csum_acc = 8'h00;
    push_byte(dst[15:8]);  push_byte(dst[7:0]);
    push_byte(src[15:8]);  push_byte(src[7:0]);
    push_byte(size[15:8]); push_byte(size[7:0]);
    push_byte({dir, typ});
    for (int k = 0; k < int'(size); k++) push_byte(pay_byte(seed, k));
    if (TRL == 1) push_byte(csum_acc ^ (bad_csum ? 8'h01 : 8'h00));
  endtask

  task automatic wait_result(input int bound, output bit got_valid, output bit done);
    logic [7:0] d0;
    d0 = o_drop_count;
    got_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge i_clk);
      if (o_valid) begin got_valid = 1'b1; done = 1'b1; end
      else if (o_drop_count != d0) done = 1'b1;
    end
  endtask

  task automatic do_ack(input int dly);
    repeat (dly) @(negedge i_clk);
    i_ack = 1'b1;
    @(negedge i_clk);
    i_ack = 1'b0;
    check("valid_low_after_ack", 32'(o_valid), 32'd0);
    check_pay("payload_cleared", o_payload, '0);
  endtask

  typedef struct {
    logic [15:0] dst;
    logic [15:0] src;
    logic [15:0] size;
    logic        dir;
    logic [6:0]  typ;
    logic [7:0]  seed;
    logic        acc;
    int          ack_dly;
  } vec_t;

  vec_t vecs[7];

  task automatic check_fields(input vec_t v);
    check("dst", 32'(o_dst), 32'(v.dst));
    check("src", 32'(o_src), 32'(v.src));
    check("size", 32'(o_size), 32'(v.size));
    check("dir", 32'(o_dir), 32'(v.dir));
    check("type", 32'(o_type), 32'(v.typ));
    if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else check_pay("payload", o_payload, exp_q.pop_front());
  endtask

  task automatic run_vector(input string tag, input vec_t v);
    int r0;
    bit gv, done;
    r0 = rreq_cnt;
    if (v.acc) exp_q.push_back(exp_pay(v.seed, int'(v.size)));
    push_frame(v.dst, v.src, v.size, v.dir, v.typ, v.seed, 1'b0);
    wait_result(2000, gv, done);
    check({tag, "_resolved"}, 32'(done), 32'd1);
    check({tag, "_accept"}, 32'(gv), 32'(v.acc));
    if (gv) begin
      check({tag, "_latency"}, 32'(cyc - last_rreq), 32'd3);
      check_fields(v);
      exp_rx++;
      check({tag, "_rx_count"}, 32'(o_rx_count), 32'(exp_rx[7:0]));
      do_ack(v.ack_dly);
    end else begin
      exp_drop++;
      check({tag, "_drop_count"}, 32'(o_drop_count), 32'(exp_drop[7:0]));
    end
    check({tag, "_rreq_pulses"}, 32'(rreq_cnt - r0), 32'(7 + int'(v.size) + TRL));
  endtask

  // ---------------- test ----------------
  initial begin
    int r0, bad;
    bit gv, done;
    vec_t va, vb;

    vecs[0] = '{16'hFFFF, 16'h0001, 16'd2,  1'b1, 7'h03, 8'hAA, 1'b1, 3};
    vecs[1] = '{16'h0005, 16'h0001, 16'd4,  1'b0, 7'h03, 8'h10, 1'b0, 0};
    vecs[2] = '{16'hFFFF, 16'h0002, 16'd3,  1'b0, 7'h05, 8'h20, 1'b1, 0};
    vecs[3] = '{16'h0000, 16'hABCD, 16'd42, 1'b1, 7'h10, 8'h00, 1'b1, 1};
    vecs[4] = '{16'h0000, 16'h1234, 16'd0,  1'b0, 7'h7F, 8'h00, 1'b1, 2};
    vecs[5] = '{16'hFFFF, 16'h0003, 16'd43, 1'b0, 7'h03, 8'h30, 1'b0, 0};
    vecs[6] = '{16'h0000, 16'h0004, 16'd5,  1'b1, 7'h04, 8'h60, 1'b1, 0};

    repeat (3) @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_dst", 32'(o_dst), 32'd0);
    check("rst_rx_count", 32'(o_rx_count), 32'd0);
    check("rst_drop_count", 32'(o_drop_count), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_no_rreq", 32'(o_rreq), 32'd0);

    for (int i = 0; i < 7; i++) run_vector($sformatf("vec%0d", i), vecs[i]);

    // Truncated frame: only bytes 0-3 ever arrive, so the timeout must abort it.
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h00); push_byte(8'h01);
    wait_result(2000, gv, done);
    check("timeout_resolved", 32'(done), 32'd1);
    check("timeout_no_valid", 32'(gv), 32'd0);
    exp_drop++;
    check("timeout_drop_count", 32'(o_drop_count), 32'(exp_drop[7:0]));
    check("timeout_dst_kept", 32'(o_dst), 32'hFFFF);
    run_vector("after_timeout", '{16'hFFFF, 16'h0077, 16'd2, 1'b0, 7'h03, 8'h42, 1'b1, 0});

    // Two frames queued; the second must not be touched while the first is held.
    va = '{16'hFFFF, 16'h0011, 16'd3, 1'b1, 7'h10, 8'h10, 1'b1, 0};
    vb = '{16'h0000, 16'h0022, 16'd4, 1'b0, 7'h04, 8'h40, 1'b1, 0};
    r0 = rreq_cnt;
    exp_q.push_back(exp_pay(va.seed, 3));
    exp_q.push_back(exp_pay(vb.seed, 4));
    push_frame(va.dst, va.src, va.size, va.dir, va.typ, va.seed, 1'b0);
    push_frame(vb.dst, vb.src, vb.size, vb.dir, vb.typ, vb.seed, 1'b0);
    wait_result(2000, gv, done);
    check("b2b_first_valid", 32'(gv), 32'd1);
    check_fields(va);
    check("b2b_first_rreq", 32'(rreq_cnt - r0), 32'(10 + TRL));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_rreq || !o_valid) bad++;
    end
    check("b2b_hold_quiet", 32'(bad), 32'd0);
    check("b2b_no_extra_rreq", 32'(rreq_cnt - r0), 32'(10 + TRL));
    exp_rx++;
    do_ack(0);
    wait_result(2000, gv, done);
    check("b2b_second_valid", 32'(gv), 32'd1);
    check_fields(vb);
    exp_rx++;
    check("b2b_rx_count", 32'(o_rx_count), 32'(exp_rx[7:0]));
    do_ack(2);

`ifdef MHP_FRAME_PARSER_CSUM_EN
    push_frame(16'hFFFF, 16'h0099, 16'd3, 1'b0, 7'h03, 8'h55, 1'b1);
    wait_result(2000, gv, done);
    check("csum_bad_no_valid", 32'(gv), 32'd0);
    exp_drop++;
    check("csum_bad_drop_count", 32'(o_drop_count), 32'(exp_drop[7:0]));
`endif

    // Reset in the middle of a payload clears every output on the next cycle.
    r0 = rreq_cnt;
    push_frame(16'hFFFF, 16'h0123, 16'd20, 1'b1, 7'h10, 8'h01, 1'b0);
    for (int i = 0; i < 100 && (rreq_cnt - r0) < 12; i++) @(negedge i_clk);
    check("rst_mid_progress", 32'((rreq_cnt - r0) >= 12), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst_rreq", 32'(o_rreq), 32'd0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_dst", 32'(o_dst), 32'd0);
    check("midrst_src", 32'(o_src), 32'd0);
    check("midrst_size", 32'(o_size), 32'd0);
    check("midrst_dirtype", 32'({o_dir, o_type}), 32'd0);
    check_pay("midrst_payload", o_payload, '0);
    check("midrst_rx_count", 32'(o_rx_count), 32'd0);
    check("midrst_drop_count", 32'(o_drop_count), 32'd0);
    check("no_fifo_underflow", 32'(underflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
